// File: rtl/address_sequencer.sv
// ---------------------------------------------------------------------------
// AddressSequencer
//
// Walks a memory address through an inclusive region [startAddress,
// endAddress] for a record or a play pass. In RECORD the deserializer's
// sample-complete strobe moves it forward; in PLAY the serializer's strobe
// does. At the end of the region the pass either finishes (DONE) or loops
// back to the start, with a one-cycle wrapped pulse when it loops.
//
// Ports
//   clock        : single clock; all state changes on its rising edge
//   reset        : asynchronous, active-low reset
//   startRecord  : one-cycle request to begin a record pass
//   startPlay    : one-cycle request to begin a play pass
//   stop         : abort the current pass and return to IDLE
//   loopEn       : wrap at the end of the region instead of finishing (live)
//   desDone      : deserializer strobe, advances the address in RECORD
//   sDone        : serializer strobe, advances the address in PLAY
//   startAddress : first address of the region
//   endAddress   : last address of the region, inclusive
//   address      : current memory address
//   mode         : IDLE=0, RECORD=1, PLAY=2, DONE=3
//   busy         : high in RECORD or PLAY
//   done         : high while in DONE
//   wrapped      : one-cycle pulse on each loop wrap
// ---------------------------------------------------------------------------
module address_sequencer #(
   parameter int ADDR_W = 17
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              startRecord,
   input  logic              startPlay,
   input  logic              stop,
   input  logic              loopEn,
   input  logic              desDone,
   input  logic              sDone,
   input  logic [ADDR_W-1:0] startAddress,
   input  logic [ADDR_W-1:0] endAddress,
   output logic [ADDR_W-1:0] address,
   output logic [1:0]        mode,
   output logic              busy,
   output logic              done,
   output logic              wrapped
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RECORD = 2'd1,
      PLAY   = 2'd2,
      DONE   = 2'd3
   } seqState_e;

   localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

   seqState_e         stateQ, stateD;
   logic [ADDR_W-1:0] addressQ, addressD;
   logic [ADDR_W-1:0] startRegQ, startRegD;
   logic [ADDR_W-1:0] endRegQ, endRegD;
   logic              wrappedQ, wrappedD;
   logic              advance;

   // An advance is the strobe that belongs to the current pass type; the
   // other strobe is ignored, and having both high still counts only once.
   always_comb begin
      advance = ((stateQ == RECORD) && desDone) || ((stateQ == PLAY) && sDone);
   end

   // Next-state logic. Commands are resolved first in the fixed order
   // stop > startRecord > startPlay and apply from any state, so a start
   // during a pass restarts it. A start cycle reloads the region bounds and
   // swallows any strobe seen in that same cycle. The region bounds are only
   // latched on a start so that the inputs can change freely mid-pass.
   // Address arithmetic wraps modulo 2^ADDR_W, which lets a region whose end
   // is below its start run across the top of memory.
   always_comb begin
      stateD    = stateQ;
      addressD  = addressQ;
      startRegD = startRegQ;
      endRegD   = endRegQ;
      wrappedD  = 1'b0;

      if (stop) begin
         stateD = IDLE;
      end else if (startRecord || startPlay) begin
         stateD    = startRecord ? RECORD : PLAY;
         addressD  = startAddress;
         startRegD = startAddress;
         endRegD   = endAddress;
      end else if (advance) begin
         if (addressQ != endRegQ) begin
            addressD = addressQ + ONE;
         end else if (loopEn) begin
            addressD = startRegQ;
            wrappedD = 1'b1;
         end else begin
            stateD = DONE;
         end
      end
   end

   // State register. Reset is asynchronous so that a pass in progress is
   // dropped immediately, without waiting for a clock edge and without
   // emitting a done or wrapped indication.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         stateQ    <= IDLE;
         addressQ  <= '0;
         startRegQ <= '0;
         endRegQ   <= '0;
         wrappedQ  <= 1'b0;
      end else begin
         stateQ    <= stateD;
         addressQ  <= addressD;
         startRegQ <= startRegD;
         endRegQ   <= endRegD;
         wrappedQ  <= wrappedD;
      end
   end

   // Status outputs come straight from the state register, so busy and done
   // can never be high together.
   assign address = addressQ;
   assign mode    = stateQ;
   assign busy    = (stateQ == RECORD) || (stateQ == PLAY);
   assign done    = (stateQ == DONE);
   assign wrapped = wrappedQ;

endmodule

// File: tb/tb_address_sequencer.sv
// ---------------------------------------------------------------------------
// tb_address_sequencer
//
// Directed-vector bench for address_sequencer. Each task drives one scenario
// and compares the packed status {mode, busy, done, wrapped, address} against
// hand-computed values one microsecond-free step (#1) after the rising edge.
// ---------------------------------------------------------------------------
module tb_address_sequencer;

   localparam int ADDR_W = 17;

   logic              clock = 1'b0;
   logic              reset = 1'b1;
   logic              startRecord = 1'b0;
   logic              startPlay = 1'b0;
   logic              stop = 1'b0;
   logic              loopEn = 1'b0;
   logic              desDone = 1'b0;
   logic              sDone = 1'b0;
   logic [ADDR_W-1:0] startAddress = '0;
   logic [ADDR_W-1:0] endAddress = '0;
   logic [ADDR_W-1:0] address;
   logic [1:0]        mode;
   logic              busy;
   logic              done;
   logic              wrapped;

   int vectors = 0;
   int miscompares = 0;

   // Packed status: mode[21:20] busy[19] done[18] wrapped[17] address[16:0]
   logic [ADDR_W+4:0] obs;
   assign obs = {mode, busy, done, wrapped, address};

   address_sequencer #(.ADDR_W(ADDR_W)) dut (
      .clock       (clock),
      .reset       (reset),
      .startRecord (startRecord),
      .startPlay   (startPlay),
      .stop        (stop),
      .loopEn      (loopEn),
      .desDone     (desDone),
      .sDone       (sDone),
      .startAddress(startAddress),
      .endAddress  (endAddress),
      .address     (address),
      .mode        (mode),
      .busy        (busy),
      .done        (done),
      .wrapped     (wrapped)
   );

   always #5 clock = ~clock;

   // Clock one rising edge, step past it, then drop all one-shot inputs so
   // that whatever was set beforehand is seen for exactly one edge.
   task automatic applyStimulus();
      @(posedge clock);
      #1;
      startRecord = 1'b0;
      startPlay   = 1'b0;
      stop        = 1'b0;
      desDone     = 1'b0;
      sDone       = 1'b0;
   endtask

   // Reset forces IDLE/address 0 without a clock edge; strobes in IDLE do nothing.
   task automatic test_reset();
      #1 reset = 1'b0;
      #1;
      vectors++;
      if (obs !== {2'd0, 1'b0, 1'b0, 1'b0, 17'h00000}) begin
         miscompares++;
         $display("FAIL reset_async: got %h expected %h", obs, {2'd0, 1'b0, 1'b0, 1'b0, 17'h00000});
      end
      applyStimulus();
      applyStimulus();
      reset = 1'b1;
      desDone = 1'b1;
      sDone = 1'b1;
      applyStimulus();
      vectors++;
      if (obs !== {2'd0, 1'b0, 1'b0, 1'b0, 17'h00000}) begin
         miscompares++;
         $display("FAIL idle_strobes: got %h expected %h", obs, {2'd0, 1'b0, 1'b0, 1'b0, 17'h00000});
      end
   endtask

   // Terminating play pass 0x10..0x12, strobe on the start cycle ignored.
   task automatic test_play_terminate();
      loopEn = 1'b0;
      startAddress = 17'h00010;
      endAddress = 17'h00012;
      startPlay = 1'b1;
      sDone = 1'b1;
      applyStimulus();
      vectors++;
      if (obs !== {2'd2, 1'b1, 1'b0, 1'b0, 17'h00010}) begin
         miscompares++;
         $display("FAIL play_start: got %h expected %h", obs, {2'd2, 1'b1, 1'b0, 1'b0, 17'h00010});
      end
      sDone = 1'b1;
      applyStimulus();
      vectors++;
      if (obs !== {2'd2, 1'b1, 1'b0, 1'b0, 17'h00011}) begin
         miscompares++;
         $display("FAIL play_adv1: got %h expected %h", obs, {2'd2, 1'b1, 1'b0, 1'b0, 17'h00011});
      end
      sDone = 1'b1;
      applyStimulus();
      vectors++;
      if (obs !== {2'd2, 1'b1, 1'b0, 1'b0, 17'h00012}) begin
         miscompares++;
         $display("FAIL play_adv2: got %h expected %h", obs, {2'd2, 1'b1, 1'b0, 1'b0, 17'h00012});
      end
      sDone = 1'b1;
      applyStimulus();
      vectors++;
      if (obs !== {2'd3, 1'b0, 1'b1, 1'b0, 17'h00012}) begin
         miscompares++;
         $display("FAIL play_done: got %h expected %h", obs, {2'd3, 1'b0, 1'b1, 1'b0, 17'h00012});
      end
      sDone = 1'b1;
      desDone = 1'b1;
      applyStimulus();
      vectors++;
      if (obs !== {2'd3, 1'b0, 1'b1, 1'b0, 17'h00012}) begin
         miscompares++;
         $display("FAIL done_hold: got %h expected %h", obs, {2'd3, 1'b0, 1'b1, 1'b0, 17'h00012});
      end
   endtask

   // Looping record pass 5..6 with wrap pulses; sDone ignored in RECORD.
   task automatic test_record_loop();
      loopEn = 1'b1;
      startAddress = 17'h00005;
      endAddress = 17'h00006;
      startRecord = 1'b1;
      applyStimulus();
      vectors++;
      if (obs !== {2'd1, 1'b1, 1'b0, 1'b0, 17'h00005}) begin
         miscompares++;
         $display("FAIL rec_start: got %h expected %h", obs, {2'd1, 1'b1, 1'b0, 1'b0, 17'h00005});
      end
      sDone = 1'b1;
      applyStimulus();
      vectors++;
      if (obs !== {2'd1, 1'b1, 1'b0, 1'b0, 17'h00005}) begin
         miscompares++;
         $display("FAIL rec_sdone_ignored: got %h expected %h", obs, {2'd1, 1'b1, 1'b0, 1'b0, 17'h00005});
      end
      desDone = 1'b1;
      sDone = 1'b1;
      applyStimulus();
      vectors++;
      if (obs !== {2'd1, 1'b1, 1'b0, 1'b0, 17'h00006}) begin
         miscompares++;
         $display("FAIL rec_adv1: got %h expected %h", obs, {2'd1, 1'b1, 1'b0, 1'b0, 17'h00006});
      end
      desDone = 1'b1;
      applyStimulus();
      vectors++;
      if (obs !== {2'd1, 1'b1, 1'b0, 1'b1, 17'h00005}) begin
         miscompares++;
         $display("FAIL rec_wrap1: got %h expected %h", obs, {2'd1, 1'b1, 1'b0, 1'b1, 17'h00005});
      end
      desDone = 1'b1;
      applyStimulus();
      vectors++;
      if (obs !== {2'd1, 1'b1, 1'b0, 1'b0, 17'h00006}) begin
         miscompares++;
         $display("FAIL rec_adv3: got %h expected %h", obs, {2'd1, 1'b1, 1'b0, 1'b0, 17'h00006});
      end
      desDone = 1'b1;
      applyStimulus();
      vectors++;
      if (obs !== {2'd1, 1'b1, 1'b0, 1'b1, 17'h00005}) begin
         miscompares++;
         $display("FAIL rec_wrap2: got %h expected %h", obs, {2'd1, 1'b1, 1'b0, 1'b1, 17'h00005});
      end
      applyStimulus();
      vectors++;
      if (obs !== {2'd1, 1'b1, 1'b0, 1'b0, 17'h00005}) begin
         miscompares++;
         $display("FAIL rec_wrap_pulse_end: got %h expected %h", obs, {2'd1, 1'b1, 1'b0, 1'b0, 17'h00005});
      end
   endtask

   // Region spanning the top of memory; bound inputs changed mid-pass.
   task automatic test_top_wrap();
      loopEn = 1'b0;
      startAddress = 17'h1FFFE;
      endAddress = 17'h00001;
      startPlay = 1'b1;
      applyStimulus();
      startAddress = 17'h00100;
      endAddress = 17'h00000;
      sDone = 1'b1;
      applyStimulus();
      vectors++;
      if (obs !== {2'd2, 1'b1, 1'b0, 1'b0, 17'h1FFFF}) begin
         miscompares++;
         $display("FAIL top_adv1: got %h expected %h", obs, {2'd2, 1'b1, 1'b0, 1'b0, 17'h1FFFF});
      end
      sDone = 1'b1;
      applyStimulus();
      vectors++;
      if (obs !== {2'd2, 1'b1, 1'b0, 1'b0, 17'h00000}) begin
         miscompares++;
         $display("FAIL top_rollover: got %h expected %h", obs, {2'd2, 1'b1, 1'b0, 1'b0, 17'h00000});
      end
      sDone = 1'b1;
      applyStimulus();
      vectors++;
      if (obs !== {2'd2, 1'b1, 1'b0, 1'b0, 17'h00001}) begin
         miscompares++;
         $display("FAIL top_adv3: got %h expected %h", obs, {2'd2, 1'b1, 1'b0, 1'b0, 17'h00001});
      end
      sDone = 1'b1;
      applyStimulus();
      vectors++;
      if (obs !== {2'd3, 1'b0, 1'b1, 1'b0, 17'h00001}) begin
         miscompares++;
         $display("FAIL top_done: got %h expected %h", obs, {2'd3, 1'b0, 1'b1, 1'b0, 17'h00001});
      end
   endtask

   // Command priority, stop holding address, strobe type per mode, restart.
   task automatic test_stop_priority();
      loopEn = 1'b0;
      startAddress = 17'h00020;
      endAddress = 17'h00030;
      startRecord = 1'b1;
      applyStimulus();
      stop = 1'b1;
      startPlay = 1'b1;
      desDone = 1'b1;
      applyStimulus();
      vectors++;
      if (obs !== {2'd0, 1'b0, 1'b0, 1'b0, 17'h00020}) begin
         miscompares++;
         $display("FAIL stop_priority: got %h expected %h", obs, {2'd0, 1'b0, 1'b0, 1'b0, 17'h00020});
      end
      startAddress = 17'h00040;
      endAddress = 17'h00050;
      startPlay = 1'b1;
      applyStimulus();
      desDone = 1'b1;
      applyStimulus();
      vectors++;
      if (obs !== {2'd2, 1'b1, 1'b0, 1'b0, 17'h00040}) begin
         miscompares++;
         $display("FAIL play_desdone_ignored: got %h expected %h", obs, {2'd2, 1'b1, 1'b0, 1'b0, 17'h00040});
      end
      sDone = 1'b1;
      applyStimulus();
      startAddress = 17'h00060;
      startRecord = 1'b1;
      startPlay = 1'b1;
      applyStimulus();
      vectors++;
      if (obs !== {2'd1, 1'b1, 1'b0, 1'b0, 17'h00060}) begin
         miscompares++;
         $display("FAIL restart_record_wins: got %h expected %h", obs, {2'd1, 1'b1, 1'b0, 1'b0, 17'h00060});
      end
   endtask

   // Asynchronous reset in the middle of a play pass.
   task automatic test_async_reset();
      loopEn = 1'b1;
      startAddress = 17'h00033;
      endAddress = 17'h00040;
      startPlay = 1'b1;
      applyStimulus();
      @(negedge clock);
      #2 reset = 1'b0;
      #1;
      vectors++;
      if (obs !== {2'd0, 1'b0, 1'b0, 1'b0, 17'h00000}) begin
         miscompares++;
         $display("FAIL midpass_reset: got %h expected %h", obs, {2'd0, 1'b0, 1'b0, 1'b0, 17'h00000});
      end
      applyStimulus();
      reset = 1'b1;
      sDone = 1'b1;
      applyStimulus();
      applyStimulus();
      vectors++;
      if (obs !== {2'd0, 1'b0, 1'b0, 1'b0, 17'h00000}) begin
         miscompares++;
         $display("FAIL post_reset_hold: got %h expected %h", obs, {2'd0, 1'b0, 1'b0, 1'b0, 17'h00000});
      end
   endtask

   // One-word region: wraps every advance, then terminates with loopEn low.
   task automatic test_one_word();
      loopEn = 1'b1;
      startAddress = 17'h00007;
      endAddress = 17'h00007;
      startRecord = 1'b1;
      applyStimulus();
      desDone = 1'b1;
      applyStimulus();
      vectors++;
      if (obs !== {2'd1, 1'b1, 1'b0, 1'b1, 17'h00007}) begin
         miscompares++;
         $display("FAIL oneword_wrap: got %h expected %h", obs, {2'd1, 1'b1, 1'b0, 1'b1, 17'h00007});
      end
      loopEn = 1'b0;
      desDone = 1'b1;
      applyStimulus();
      vectors++;
      if (obs !== {2'd3, 1'b0, 1'b1, 1'b0, 17'h00007}) begin
         miscompares++;
         $display("FAIL oneword_done: got %h expected %h", obs, {2'd3, 1'b0, 1'b1, 1'b0, 17'h00007});
      end
      stop = 1'b1;
      applyStimulus();
      vectors++;
      if (obs !== {2'd0, 1'b0, 1'b0, 1'b0, 17'h00007}) begin
         miscompares++;
         $display("FAIL done_stop: got %h expected %h", obs, {2'd0, 1'b0, 1'b0, 1'b0, 17'h00007});
      end
   endtask

   initial begin
      $display("[TB] address_sequencer directed test start");
      test_reset();
      test_play_terminate();
      test_record_loop();
      test_top_wrap();
      test_stop_priority();
      test_async_reset();
      test_one_word();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
